// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit driving a dmem port that may need
// many cycles per access. Aligns store data, builds byte-lane masks,
// extends load data and reports faults (misaligned, illegal funct3, timeout).
// Optional feature macro: LSU_MISALIGNED_SPLIT_EN. When it is defined, an access
// that crosses a bus word is split into two dmem transactions. When it is not
// defined, any misaligned access returns an error response.
//
// state | meaning
// IDLE  | ready for a request; completion pulse of the previous access shows here
// ACC1  | first (or only) dmem access in flight
// ACC2  | second half of a word-crossing access in flight
// FAULT | one-cycle error response, dmem masks stay 0
module lsu_mem_stage #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic [XLEN-1:0]   dmem_address,
  output logic [XLEN/8-1:0] dmem_rmask,
  output logic [XLEN/8-1:0] dmem_wmask,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_resp
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int EW   = OFFW + 2;
  localparam int WDW  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2, S_FAULT} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic              split_q, split_d;
  logic [4:0]        rd_q, rd_d;
  logic [WDW-1:0]    wd_q, wd_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [NB-1:0]     hi_mask_q, hi_mask_d;
  logic [XLEN-1:0]   hi_wdata_q, hi_wdata_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [NB-1:0]     rmask_q, rmask_d;
  logic [NB-1:0]     wmask_q, wmask_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              rvalid_q, rvalid_d;
  logic              rerr_q, rerr_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [4:0]        rrd_q, rrd_d;

  // request decode
  logic [3:0]        acc_bytes;
  logic [OFFW-1:0]   acc_off;
  logic [OFFW-1:0]   acc_size_mask;
  logic              acc_illegal;
  logic              acc_misal;
  logic [EW-1:0]     acc_end;
  logic              acc_split;
  logic              acc_fault;
  logic [NB-1:0]     acc_base;
  logic [XLEN-1:0]   acc_keep;
  logic [2*NB-1:0]   acc_lanes;
  logic [2*XLEN-1:0] acc_wdata;
  logic [XLEN-1:0]   acc_word;

  // load alignment
  logic [2*XLEN-1:0]      ld_merged;
  logic [2*XLEN-1:0]      ld_shifted;
  logic [XLEN-1:0]        ld_val;
  int                     ld_sh;
  logic [XLEN-1:0]        ld_shl;
  logic signed [XLEN-1:0] ld_sra;
  logic [XLEN-1:0]        ld_ext;

  // Decode the incoming request into lanes, shifted data and fault flags.
  // Stores never use the unsigned funct3 encodings, so those count as illegal.
  always_comb begin
    acc_bytes     = 4'd1 << req_funct3[1:0];
    acc_off       = req_addr[OFFW-1:0];
    acc_size_mask = OFFW'(acc_bytes - 4'd1);
    acc_illegal   = 1'b0;
    case (req_funct3)
      3'b011:         acc_illegal = (XLEN == 32);
      3'b110:         acc_illegal = (XLEN == 32) || req_we;
      3'b100, 3'b101: acc_illegal = req_we;
      3'b111:         acc_illegal = 1'b1;
      default:        acc_illegal = 1'b0;
    endcase
    acc_misal = |(acc_off & acc_size_mask);
    acc_end   = EW'(acc_off) + EW'(acc_bytes);
    acc_split = SPLIT_EN && (acc_end > EW'(NB));
    acc_fault = acc_illegal || (!SPLIT_EN && acc_misal);
    acc_base  = NB'((32'd1 << acc_bytes) - 32'd1);
    acc_keep  = '0;
    for (int i = 0; i < NB; i++) begin
      acc_keep[8*i +: 8] = {8{acc_base[i]}};
    end
    acc_lanes = {{NB{1'b0}}, acc_base} << acc_off;
    acc_wdata = {{XLEN{1'b0}}, (req_wdata & acc_keep)} << {acc_off, 3'b000};
    acc_word  = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
  end

  // Merge the returned word(s), shift the access down to bit 0 and extend.
  always_comb begin
    ld_merged  = (state_q == S_ACC2) ? {dmem_rdata, lo_q} : {{XLEN{1'b0}}, dmem_rdata};
    ld_shifted = ld_merged >> {off_q, 3'b000};
    ld_val     = ld_shifted[XLEN-1:0];
    ld_sh      = XLEN - (8 << size_q);
    ld_shl     = ld_val << ld_sh;
    ld_sra     = $signed(ld_shl) >>> ld_sh;
    ld_ext     = uns_q ? (ld_shl >> ld_sh) : ld_sra;
  end

  // Next-state and registered-output logic; the response signals pulse for one cycle.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    off_d      = off_q;
    split_d    = split_q;
    rd_d       = rd_q;
    wd_d       = wd_q;
    lo_d       = lo_q;
    hi_mask_d  = hi_mask_q;
    hi_wdata_d = hi_wdata_q;
    addr_d     = addr_q;
    rmask_d    = rmask_q;
    wmask_d    = wmask_q;
    wdata_d    = wdata_q;
    rvalid_d   = 1'b0;
    rerr_d     = 1'b0;
    rdata_d    = '0;
    rrd_d      = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_funct3[1:0];
          uns_d   = req_funct3[2];
          off_d   = acc_off;
          split_d = acc_split;
          rd_d    = req_rd;
          if (acc_fault) begin
            state_d  = S_FAULT;
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
            rrd_d    = req_rd;
          end else begin
            state_d    = S_ACC1;
            wd_d       = WDW'(MAX_WAIT);
            addr_d     = acc_word;
            rmask_d    = req_we ? '0 : acc_lanes[NB-1:0];
            wmask_d    = req_we ? acc_lanes[NB-1:0] : '0;
            wdata_d    = req_we ? acc_wdata[XLEN-1:0] : '0;
            hi_mask_d  = acc_lanes[2*NB-1:NB];
            hi_wdata_d = acc_wdata[2*XLEN-1:XLEN];
          end
        end
      end
      S_ACC1, S_ACC2: begin
        if (dmem_resp) begin
          if (state_q == S_ACC1 && split_q) begin
            state_d = S_ACC2;
            lo_d    = dmem_rdata;
            wd_d    = WDW'(MAX_WAIT);
            addr_d  = addr_q + XLEN'(NB);
            rmask_d = we_q ? '0 : hi_mask_q;
            wmask_d = we_q ? hi_mask_q : '0;
            wdata_d = we_q ? hi_wdata_q : '0;
          end else begin
            state_d  = S_IDLE;
            wd_d     = '0;
            addr_d   = '0;
            rmask_d  = '0;
            wmask_d  = '0;
            wdata_d  = '0;
            rvalid_d = 1'b1;
            rrd_d    = rd_q;
            rdata_d  = we_q ? '0 : ld_ext;
          end
        end else if (MAX_WAIT > 0) begin
          if (wd_q == WDW'(1)) begin
            state_d  = S_FAULT;
            wd_d     = '0;
            addr_d   = '0;
            rmask_d  = '0;
            wmask_d  = '0;
            wdata_d  = '0;
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
            rrd_d    = rd_q;
          end else begin
            wd_d = wd_q - WDW'(1);
          end
        end
      end
      S_FAULT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset; an in-flight access is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      off_q      <= '0;
      split_q    <= 1'b0;
      rd_q       <= '0;
      wd_q       <= '0;
      lo_q       <= '0;
      hi_mask_q  <= '0;
      hi_wdata_q <= '0;
      addr_q     <= '0;
      rmask_q    <= '0;
      wmask_q    <= '0;
      wdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rerr_q     <= 1'b0;
      rdata_q    <= '0;
      rrd_q      <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      off_q      <= off_d;
      split_q    <= split_d;
      rd_q       <= rd_d;
      wd_q       <= wd_d;
      lo_q       <= lo_d;
      hi_mask_q  <= hi_mask_d;
      hi_wdata_q <= hi_wdata_d;
      addr_q     <= addr_d;
      rmask_q    <= rmask_d;
      wmask_q    <= wmask_d;
      wdata_q    <= wdata_d;
      rvalid_q   <= rvalid_d;
      rerr_q     <= rerr_d;
      rdata_q    <= rdata_d;
      rrd_q      <= rrd_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign resp_valid   = rvalid_q;
  assign resp_err     = rerr_q;
  assign resp_rdata   = rdata_q;
  assign resp_rd      = rrd_q;
  assign dmem_address = addr_q;
  assign dmem_rmask   = rmask_q;
  assign dmem_wmask   = wmask_q;
  assign dmem_wdata   = wdata_q;

endmodule
